led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter N_LEDS, default 8, number of LED outputs; legal range 2..32.
REQ-002 Parameter DIV_WIDTH, default 24, width of the step prescaler.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run enable; low freezes prescaler, pattern and direction.
REQ-006 mode  input  2  pattern select: 00 bounce, 01 rotate-left, 10 rotate-right, 11 bar-fill.
REQ-007 step_div  input  DIV_WIDTH  prescaler terminal count; one step every step_div+1 enabled cycles.
REQ-008 led  output  N_LEDS  registered LED drive, bit 0 = first LED.
REQ-009 dir  output  1  registered direction, 1 = toward MSB, 0 = toward LSB.
REQ-010 step_pulse  output  1  registered, high for exactly the one cycle in which led shows a new step value.

Function
REQ-011 Prescaler counter (DIV_WIDTH bits) shall increment on each enabled cycle and generate a step tick and clear to 0 when count == step_div.
REQ-012 step_div = 0 shall produce a step tick on every enabled cycle.
REQ-013 If step_div is lowered below the current count, the counter shall continue to increment, wrap at 2^DIV_WIDTH, and tick on the next match; no other recovery.
REQ-014 With en low: counter, led and dir shall hold; step_pulse shall be 0.
REQ-015 led, dir and step_pulse shall update in the cycle after the tick cycle (latency 1 cycle from tick to new pattern).
REQ-016 Bounce (00): one-hot dot; dir=1 shifts left, dir=0 shifts right; stepping from bit N_LEDS-1 while dir=1 shall go to bit N_LEDS-2 and set dir=0; stepping from bit 0 while dir=0 shall go to bit 1 and set dir=1; each end LED lit for exactly one step.
REQ-017 Rotate-left (01): one-hot rotate toward MSB, bit N_LEDS-1 wraps to bit 0; dir forced 1.
REQ-018 Rotate-right (10): one-hot rotate toward LSB, bit 0 wraps to bit N_LEDS-1; dir forced 0.
REQ-019 Bar-fill (11): each step led <= {led[N_LEDS-2:0],1'b1} until all ones; step from all ones shall produce all zeros; step from all zeros shall produce 0...01; dir forced 1.
REQ-020 In bar-fill, a led value that is not a contiguous LSB-aligned run of ones shall be replaced at the next step by 0...01.
REQ-021 In modes 00/01/10, if led is not one-hot at a step (zero or multiple bits), the step shall load led = 0...01, dir = 1 instead of the normal move.
REQ-022 Mode changes shall take effect only at the next step tick; prescaler is not restarted by a mode change.
REQ-023 Switching into bounce shall keep the current dot and dir when led is one-hot.
REQ-024 Tick and en deassertion cannot coincide: tick is generated only on enabled cycles.

Reset
REQ-025 Asserting rst shall immediately force led = 0...01, dir = 1, step_pulse = 0, prescaler = 0, regardless of clk.
REQ-026 Reset asserted mid-sweep shall discard pattern state; first step after release follows REQ-016..019 from the reset values.
REQ-027 After rst deasserts, first step tick occurs after step_div+1 enabled cycles.

Verification
REQ-028 N_LEDS=8, mode=00, step_div=0, en=1 from reset -> led sequence 01,02,04,...,80,40,...,01,02; dir falls on the step to 40, rises on the step to 02; step_pulse high every cycle.
REQ-029 mode=01, step_div=3 -> led changes every 4th cycle 01,02,...,80,01; step_pulse high one cycle per change, dir=1 throughout.
REQ-030 mode=11, step_div=0 -> 01,03,07,...,FF,00,01; then switch to mode=10 when led=07 -> next step led=01, dir=1 (recovery), following step led=80, dir=0.
REQ-031 en deasserted for 10 cycles mid-count (step_div=5) -> led, dir, counter frozen, step_pulse 0; on re-enable remaining count completes before next step.
REQ-032 rst pulsed asynchronously between clock edges while led=20, dir=0 -> led=01, dir=1 immediately, before next clk edge.
REQ-033 N_LEDS=2, mode=00 -> led alternates 01,10,01; dir toggles each step; no dwell.

Source files
------------

// File: rtl/led_sequencer.sv
// LED pattern sequencer: a prescaler paces steps through bounce, rotate and bar-fill patterns.
// LED, direction and step pulse are registered and change in the cycle after the prescaler tick.
module led_sequencer #(
    parameter int N_LEDS    = 8,
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] step_div,
    output logic [N_LEDS-1:0]    led,
    output logic                 dir,
    output logic                 step_pulse
);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROT_L  = 2'b01,
        MODE_ROT_R  = 2'b10,
        MODE_BAR    = 2'b11
    } mode_t;

    localparam logic [N_LEDS-1:0] LED_FIRST = N_LEDS'(1);

    mode_t                mode_sel;
    logic [DIV_WIDTH-1:0] count;
    logic                 tick;
    logic                 is_one_hot;
    logic                 is_bar;
    logic                 is_full;
    logic [N_LEDS-1:0]    next_led;
    logic                 next_dir;

    assign mode_sel = mode_t'(mode);

    // The counter only advances on enabled cycles, so a tick can never fall on a disabled cycle.
    // Lowering step_div below the count lets the counter run on and wrap before matching again.
    assign tick = en && (count == step_div);

    assign is_one_hot = (led != '0) && ((led & (led - LED_FIRST)) == '0);
    assign is_bar     = (led & (led + LED_FIRST)) == '0;
    assign is_full    = &led;

    always_comb begin
        next_led = led;
        next_dir = dir;
        case (mode_sel)
            MODE_BOUNCE: begin
                if (!is_one_hot) begin
                    next_led = LED_FIRST;
                    next_dir = 1'b1;
                end else if (dir) begin
                    // Turning at the top end lights the top LED for only one step.
                    if (led[N_LEDS-1]) begin
                        next_led = led >> 1;
                        next_dir = 1'b0;
                    end else begin
                        next_led = led << 1;
                    end
                end else begin
                    if (led[0]) begin
                        next_led = led << 1;
                        next_dir = 1'b1;
                    end else begin
                        next_led = led >> 1;
                    end
                end
            end
            MODE_ROT_L: begin
                next_dir = 1'b1;
                if (!is_one_hot) begin
                    next_led = LED_FIRST;
                end else begin
                    next_led = {led[N_LEDS-2:0], led[N_LEDS-1]};
                end
            end
            MODE_ROT_R: begin
                if (!is_one_hot) begin
                    next_led = LED_FIRST;
                    next_dir = 1'b1;
                end else begin
                    next_led = {led[0], led[N_LEDS-1:1]};
                    next_dir = 1'b0;
                end
            end
            MODE_BAR: begin
                // A full bar empties; a broken bar restarts from the first LED.
                next_dir = 1'b1;
                if (is_full) begin
                    next_led = '0;
                end else if (is_bar) begin
                    next_led = {led[N_LEDS-2:0], 1'b1};
                end else begin
                    next_led = LED_FIRST;
                end
            end
            default: begin
                next_led = LED_FIRST;
                next_dir = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            led        <= LED_FIRST;
            dir        <= 1'b1;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= tick;
            if (tick) begin
                count <= '0;
                led   <= next_led;
                dir   <= next_dir;
            end else if (en) begin
                count <= count + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: table-driven vectors on an 8-LED instance plus
// hand-written reset, prescaler-wrap and 2-LED bounce sequences on a small instance.
module tb_led_sequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] step_div;
    logic [7:0]  led;
    logic        dir;
    logic        step_pulse;

    logic        rst2;
    logic        en2;
    logic [1:0]  mode2;
    logic [3:0]  step_div2;
    logic [1:0]  led2;
    logic        dir2;
    logic        step_pulse2;

    int total;
    int bad;

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] div;
        logic        en;
        logic [7:0]  led;
        logic        dir;
        logic        pulse;
    } vec_t;

    vec_t vecs[$];

    led_sequencer #(.N_LEDS(8), .DIV_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step_div(step_div),
        .led(led), .dir(dir), .step_pulse(step_pulse)
    );

    led_sequencer #(.N_LEDS(2), .DIV_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .step_div(step_div2),
        .led(led2), .dir(dir2), .step_pulse(step_pulse2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [1:0] m, input int d, input logic e,
                           input logic [7:0] l, input logic dr, input logic p);
        vec_t v;
        v.mode = m; v.div = 24'(d); v.en = e; v.led = l; v.dir = dr; v.pulse = p;
        vecs.push_back(v);
    endtask

    task automatic add_hold(input logic [1:0] m, input int d, input logic e,
                            input logic [7:0] l, input logic dr, input int n);
        for (int k = 0; k < n; k++) add_vec(m, d, e, l, dr, 1'b0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        mode     = v.mode;
        step_div = v.div;
        en       = v.en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; en = 1'b0; mode = 2'b00; step_div = '0;
        rst2 = 1'b1; en2 = 1'b0; mode2 = 2'b00; step_div2 = '0;

        // bounce, one step per cycle, full sweep up and back
        add_vec(2'b00, 0, 1, 8'h02, 1, 1);
        add_vec(2'b00, 0, 1, 8'h04, 1, 1);
        add_vec(2'b00, 0, 1, 8'h08, 1, 1);
        add_vec(2'b00, 0, 1, 8'h10, 1, 1);
        add_vec(2'b00, 0, 1, 8'h20, 1, 1);
        add_vec(2'b00, 0, 1, 8'h40, 1, 1);
        add_vec(2'b00, 0, 1, 8'h80, 1, 1);
        add_vec(2'b00, 0, 1, 8'h40, 0, 1);
        add_vec(2'b00, 0, 1, 8'h20, 0, 1);
        add_vec(2'b00, 0, 1, 8'h10, 0, 1);
        add_vec(2'b00, 0, 1, 8'h08, 0, 1);
        add_vec(2'b00, 0, 1, 8'h04, 0, 1);
        add_vec(2'b00, 0, 1, 8'h02, 0, 1);
        add_vec(2'b00, 0, 1, 8'h01, 0, 1);
        add_vec(2'b00, 0, 1, 8'h02, 1, 1);
        // bar-fill from 02 (not a bar) restarts at 01, fills, empties, refills
        add_vec(2'b11, 0, 1, 8'h01, 1, 1);
        add_vec(2'b11, 0, 1, 8'h03, 1, 1);
        add_vec(2'b11, 0, 1, 8'h07, 1, 1);
        add_vec(2'b11, 0, 1, 8'h0F, 1, 1);
        add_vec(2'b11, 0, 1, 8'h1F, 1, 1);
        add_vec(2'b11, 0, 1, 8'h3F, 1, 1);
        add_vec(2'b11, 0, 1, 8'h7F, 1, 1);
        add_vec(2'b11, 0, 1, 8'hFF, 1, 1);
        add_vec(2'b11, 0, 1, 8'h00, 1, 1);
        add_vec(2'b11, 0, 1, 8'h01, 1, 1);
        add_vec(2'b11, 0, 1, 8'h03, 1, 1);
        add_vec(2'b11, 0, 1, 8'h07, 1, 1);
        // rotate-right from a non-one-hot value recovers, then wraps 01 -> 80
        add_vec(2'b10, 0, 1, 8'h01, 1, 1);
        add_vec(2'b10, 0, 1, 8'h80, 0, 1);
        // rotate-left every 4th cycle, wrapping 80 -> 01
        add_hold(2'b01, 3, 1, 8'h80, 0, 3);
        add_vec(2'b01, 3, 1, 8'h01, 1, 1);
        add_hold(2'b01, 3, 1, 8'h01, 1, 3);
        add_vec(2'b01, 3, 1, 8'h02, 1, 1);
        add_hold(2'b01, 3, 1, 8'h02, 1, 3);
        add_vec(2'b01, 3, 1, 8'h04, 1, 1);
        // enable dropped mid-count; the remaining count completes afterwards
        add_hold(2'b01, 5, 1, 8'h04, 1, 2);
        add_hold(2'b01, 5, 0, 8'h04, 1, 10);
        add_hold(2'b01, 5, 1, 8'h04, 1, 3);
        add_vec(2'b01, 5, 1, 8'h08, 1, 1);

        #12;
        check_output("reset_led", 32'(led), 32'h01);
        check_output("reset_dir", 32'(dir), 32'h1);
        check_output("reset_pulse", 32'(step_pulse), 32'h0);
        en = 1'b1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
            check_output($sformatf("vec%0d_dir", i), 32'(dir), 32'(vecs[i].dir));
            check_output($sformatf("vec%0d_pulse", i), 32'(step_pulse), 32'(vecs[i].pulse));
        end

        // reset mid-sweep, then sweep to 20 on the way down
        rst = 1'b1; mode = 2'b00; step_div = '0; en = 1'b1;
        #3;
        check_output("midsweep_rst_led", 32'(led), 32'h01);
        rst = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_output("sweep_led_20", 32'(led), 32'h20);
        check_output("sweep_dir_0", 32'(dir), 32'h0);

        // asynchronous reset between edges takes effect at once
        #2 rst = 1'b1;
        #1;
        check_output("async_rst_led", 32'(led), 32'h01);
        check_output("async_rst_dir", 32'(dir), 32'h1);
        check_output("async_rst_pulse", 32'(step_pulse), 32'h0);
        #2 rst = 1'b0;
        step_div = 24'd2;

        // first tick after release needs step_div+1 enabled cycles
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("release_led_c%0d", k), 32'(led), (k == 3) ? 32'h02 : 32'h01);
            check_output($sformatf("release_pulse_c%0d", k), 32'(step_pulse), (k == 3) ? 32'h1 : 32'h0);
        end

        // two-LED bounce alternates with no dwell at either end
        mode2 = 2'b00; step_div2 = '0; en2 = 1'b1;
        rst2 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("n2_led_s%0d", k), 32'(led2), (k % 2 == 1) ? 32'h2 : 32'h1);
            check_output($sformatf("n2_dir_s%0d", k), 32'(dir2), (k % 2 == 1) ? 32'h1 : 32'h0);
            check_output($sformatf("n2_pulse_s%0d", k), 32'(step_pulse2), 32'h1);
        end

        // lowering step_div below the count forces a wrap through 2^DIV_WIDTH
        step_div2 = 4'd10;
        repeat (6) @(posedge clk);
        #1;
        check_output("wrap_pre_pulse", 32'(step_pulse2), 32'h0);
        step_div2 = 4'd2;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("wrap_pulse_c%0d", k), 32'(step_pulse2), (k == 13) ? 32'h1 : 32'h0);
        end
        check_output("wrap_led", 32'(led2), 32'h2);
        check_output("wrap_dir", 32'(dir2), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
